// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART-driven run/step/pause/reset control and state snapshot streamer
// Gates the datapath clock-enable and streams pc, cycle count and register words as bytes.
module debug_unit #(
   parameter int NUM_WORDS  = 32,
   parameter int ADDR_W     = 5,
   parameter int RST_CYCLES = 4
) (
   input  logic              clock_i,
   input  logic              resetGral_i,
   input  logic [7:0]        rxData_i,
   input  logic              rxValid_i,
   input  logic              halt_i,
   input  logic [7:0]        pc_i,
   input  logic [31:0]       dumpData_i,
   input  logic              txReady_i,
   output logic              dpEnable_o,
   output logic              dpReset_o,
   output logic [ADDR_W-1:0] dumpAddr_o,
   output logic [7:0]        txData_o,
   output logic              txValid_o,
   output logic              busy_o
);

   localparam logic [7:0] CMD_RUN   = 8'h63;
   localparam logic [7:0] CMD_STEP  = 8'h73;
   localparam logic [7:0] CMD_DUMP  = 8'h64;
   localparam logic [7:0] CMD_RESET = 8'h72;
   localparam logic [7:0] CMD_PAUSE = 8'h70;

   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      STEP,
      RSTDP,
      DLOAD,
      DSEND
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              fetch_q, fetch_d;
   logic [39:0]       hdr_q, hdr_d;
   logic [2:0]        hdr_left_q, hdr_left_d;
   logic [31:0]       word_q, word_d;
   logic [1:0]        wbyte_q, wbyte_d;
   logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;

   always_ff @(posedge clock_i) begin
      if (resetGral_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         fetch_q    <= 1'b0;
         hdr_q      <= '0;
         hdr_left_q <= '0;
         word_q     <= '0;
         wbyte_q    <= '0;
         rst_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         fetch_q    <= fetch_d;
         hdr_q      <= hdr_d;
         hdr_left_q <= hdr_left_d;
         word_q     <= word_d;
         wbyte_q    <= wbyte_d;
         rst_cnt_q  <= rst_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      fetch_d    = fetch_q;
      hdr_d      = hdr_q;
      hdr_left_d = hdr_left_q;
      word_d     = word_q;
      wbyte_d    = wbyte_q;
      rst_cnt_d  = rst_cnt_q;

      case (state_q)
         IDLE: begin
            if (rxValid_i) begin
               case (rxData_i)
                  CMD_RUN:   state_d = halt_i ? DLOAD : RUN;
                  CMD_STEP:  state_d = halt_i ? DLOAD : STEP;
                  CMD_DUMP:  state_d = DLOAD;
                  CMD_RESET: begin
                     state_d   = RSTDP;
                     rst_cnt_d = '0;
                     cnt_d     = '0;
                  end
                  default:   state_d = IDLE;
               endcase
               addr_d  = '0;
               fetch_d = 1'b0;
            end
         end

         RUN: begin
            cnt_d = cnt_q + 32'd1;
            // The exit cycle is still an enabled cycle; halt and 'p' together give one exit.
            if (halt_i || (rxValid_i && rxData_i == CMD_PAUSE)) begin
               state_d = DLOAD;
               addr_d  = '0;
               fetch_d = 1'b0;
            end
         end

         STEP: begin
            cnt_d   = cnt_q + 32'd1;
            state_d = DLOAD;
            addr_d  = '0;
            fetch_d = 1'b0;
         end

         RSTDP: begin
            cnt_d = '0;
            if (rst_cnt_q == RST_LAST) begin
               state_d = IDLE;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end

         DLOAD: begin
            // Cycle 0 presents the address, cycle 1 captures the registered read data.
            if (!fetch_q) begin
               fetch_d = 1'b1;
               if (addr_q == '0) begin
                  hdr_d      = {pc_i, cnt_q};
                  hdr_left_d = 3'd5;
               end
            end else begin
               fetch_d = 1'b0;
               word_d  = dumpData_i;
               wbyte_d = '0;
               state_d = DSEND;
            end
         end

         DSEND: begin
            if (txReady_i) begin
               if (hdr_left_q != 3'd0) begin
                  hdr_d      = {hdr_q[31:0], 8'h00};
                  hdr_left_d = hdr_left_q - 3'd1;
               end else begin
                  word_d = {word_q[23:0], 8'h00};
                  if (wbyte_q == 2'd3) begin
                     if (addr_q == ADDR_LAST) begin
                        state_d = IDLE;
                        addr_d  = '0;
                     end else begin
                        state_d = DLOAD;
                        addr_d  = addr_q + ADDR_W'(1);
                     end
                  end else begin
                     wbyte_d = wbyte_q + 2'd1;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign dpEnable_o = (state_q == RUN) || (state_q == STEP);
   assign dpReset_o  = (state_q == RSTDP);
   assign dumpAddr_o = addr_q;
   assign txValid_o  = (state_q == DSEND);
   assign txData_o   = (state_q != DSEND)      ? 8'h00 :
                       (hdr_left_q != 3'd0)    ? hdr_q[39:32] : word_q[31:24];
   assign busy_o     = (state_q != IDLE);

endmodule
